// File: rtl/cr16_run_ctrl_if.sv
// rtl/cr16_run_ctrl_if.sv - board/core side handshake and status bundle for cr16_run_ctrl
interface cr16_run_ctrl_if;
  logic        I_RUN;
  logic        I_HALT;
  logic        I_STEP;
  logic [15:0] I_PC;
  logic [15:0] I_RESULT_BUS;
  logic [15:0] I_INSPECT_DATA;
  logic        O_CPU_ENABLE;
  logic [1:0]  O_STATE;
  logic [1:0]  O_HALT_CAUSE;
  logic [2:0]  O_BREAK_INDEX;

  modport master (
    output I_RUN, I_HALT, I_STEP, I_PC, I_RESULT_BUS, I_INSPECT_DATA,
    input  O_CPU_ENABLE, O_STATE, O_HALT_CAUSE, O_BREAK_INDEX
  );

  modport slave (
    input  I_RUN, I_HALT, I_STEP, I_PC, I_RESULT_BUS, I_INSPECT_DATA,
    output O_CPU_ENABLE, O_STATE, O_HALT_CAUSE, O_BREAK_INDEX
  );
endinterface

// File: rtl/cr16_run_ctrl.sv
// rtl/cr16_run_ctrl.sv - CR16 run/halt/step clock-enable controller; optional watchdog under CR16_RUN_CTRL_WATCHDOG_EN
module cr16_run_ctrl #(
  parameter logic [15:0] P_WARMUP_CYCLES   = 16'd2,
  parameter bit          P_AUTO_RUN        = 1'b1,
  parameter bit          P_ENABLE_MAX_PC   = 1'b1,
  parameter logic [15:0] P_MAX_PC          = 16'd20,
  parameter int          P_NUM_BREAKPOINTS = 2,
  parameter int          P_NUM_DIGITS      = 6,
  parameter int          P_CYCLE_WIDTH     = 32
`ifdef CR16_RUN_CTRL_WATCHDOG_EN
  , parameter int unsigned P_WATCHDOG_CYCLES = 1000
`endif
) (
  input  logic                           I_CLK,
  input  logic                           I_NRESET,
  cr16_run_ctrl_if.slave                 bus,
  input  logic [16*P_NUM_BREAKPOINTS-1:0] I_BREAK_ADDR,
  input  logic [P_NUM_BREAKPOINTS-1:0]   I_BREAK_VALID,
  output logic [P_CYCLE_WIDTH-1:0]       O_CYCLE_COUNT,
  output logic [4*P_NUM_DIGITS-1:0]      O_DISPLAY_BITS
`ifdef CR16_RUN_CTRL_WATCHDOG_EN
  , output logic                         O_WATCHDOG_TRIP
`endif
);

  localparam int DISP_W  = 4 * P_NUM_DIGITS;
  localparam int PC_BITS = ((DISP_W - 16) < 16) ? (DISP_W - 16) : 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              warm_cnt_q, warm_cnt_d;
  logic [1:0]               cause_q, cause_d;
  logic [2:0]               bidx_q, bidx_d;
  logic [P_CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic                     run_prev_q, run_prev_d;
  logic                     halt_prev_q, halt_prev_d;
  logic                     step_prev_q, step_prev_d;
  logic                     skip_q, skip_d;

  logic       run_req, halt_req, step_req;
  logic       maxpc_hit, bp_hit, run_stop, wd_expired, cpu_en;
  logic [2:0] bp_idx;
  logic [DISP_W-1:0] disp;

  assign run_req   = bus.I_RUN  & ~run_prev_q;
  assign halt_req  = bus.I_HALT & ~halt_prev_q;
  assign step_req  = bus.I_STEP & ~step_prev_q;
  assign maxpc_hit = P_ENABLE_MAX_PC & (bus.I_PC > P_MAX_PC);
  assign run_stop  = halt_req | maxpc_hit | (bp_hit & ~skip_q) | wd_expired;

`ifdef CR16_RUN_CTRL_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_trip_q, wd_trip_d;

  assign wd_expired      = (state_q == ST_RUN) && (wd_cnt_q == 32'(P_WATCHDOG_CYCLES));
  assign O_WATCHDOG_TRIP = wd_trip_q;

  // watchdog registers: consecutive enabled RUN cycles and the sticky trip flag
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_trip_q <= wd_trip_d;
    end
  end

  // watchdog count restarts whenever RUN is left; trip clears on the next run request
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    wd_trip_d = wd_trip_q;
    if (state_q != ST_RUN) wd_cnt_d = '0;
    else if (cpu_en)       wd_cnt_d = wd_cnt_q + 32'd1;
    if (run_req)    wd_trip_d = 1'b0;
    if (wd_expired) wd_trip_d = 1'b1;
  end
`else
  assign wd_expired = 1'b0;
`endif

  // breakpoint compare: scan high to low so the lowest matching index wins
  always_comb begin
    bp_hit = 1'b0;
    bp_idx = 3'd0;
    for (int k = P_NUM_BREAKPOINTS - 1; k >= 0; k--) begin
      if (I_BREAK_VALID[k] && (bus.I_PC == I_BREAK_ADDR[16*k +: 16])) begin
        bp_hit = 1'b1;
        bp_idx = 3'(k);
      end
    end
  end

  // state register plus all controller flops
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q     <= ST_WARMUP;
      warm_cnt_q  <= '0;
      cause_q     <= 2'd0;
      bidx_q      <= 3'd0;
      cycle_q     <= '0;
      run_prev_q  <= 1'b0;
      halt_prev_q <= 1'b0;
      step_prev_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      cause_q     <= cause_d;
      bidx_q      <= bidx_d;
      cycle_q     <= cycle_d;
      run_prev_q  <= run_prev_d;
      halt_prev_q <= halt_prev_d;
      step_prev_q <= step_prev_d;
      skip_q      <= skip_d;
    end
  end

  // next state, halt cause/index latching and the resume-skip flag
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    bidx_d  = bidx_q;
    skip_d  = skip_q;
    case (state_q)
      ST_WARMUP: begin
        if (warm_cnt_q == P_WARMUP_CYCLES - 16'd1)
          state_d = P_AUTO_RUN ? ST_RUN : ST_HALTED;
      end
      ST_RUN: begin
        skip_d = 1'b0;
        if (run_stop) begin
          state_d = ST_HALTED;
          if (halt_req || wd_expired) cause_d = 2'd1;
          else if (maxpc_hit)         cause_d = 2'd2;
          else begin
            cause_d = 2'd3;
            bidx_d  = bp_idx;
          end
        end
      end
      ST_HALTED: begin
        if (maxpc_hit) begin
          cause_d = 2'd2;
        end else if (halt_req) begin
          state_d = ST_HALTED;
        end else if (step_req) begin
          state_d = ST_STEP;
        end else if (run_req) begin
          state_d = ST_RUN;
          cause_d = 2'd0;
          skip_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // outputs: core clock-enable and display source mux
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = ~run_stop;
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
    disp = '0;
    if (state_q == ST_HALTED) begin
      disp[15:0] = bus.I_INSPECT_DATA;
    end else begin
      disp[15:0] = bus.I_RESULT_BUS;
      for (int i = 0; i < PC_BITS; i++) disp[16+i] = bus.I_PC[i];
    end
  end

  // counters and edge-detect history
  always_comb begin
    warm_cnt_d  = warm_cnt_q;
    cycle_d     = cycle_q;
    run_prev_d  = bus.I_RUN;
    halt_prev_d = bus.I_HALT;
    step_prev_d = bus.I_STEP;
    if (state_q == ST_WARMUP) warm_cnt_d = warm_cnt_q + 16'd1;
    if (cpu_en && !(&cycle_q)) cycle_d = cycle_q + 1'b1;
  end

  assign bus.O_CPU_ENABLE  = cpu_en;
  assign bus.O_STATE       = state_q;
  assign bus.O_HALT_CAUSE  = cause_q;
  assign bus.O_BREAK_INDEX = bidx_q;
  assign O_CYCLE_COUNT     = cycle_q;
  assign O_DISPLAY_BITS    = disp;

endmodule

// File: tb/tb_cr16_run_ctrl.sv
// tb/tb_cr16_run_ctrl.sv - directed vector bench for cr16_run_ctrl
module tb_cr16_run_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nrst2 = 1'b0;
  logic [31:0] brk_addr;
  logic [1:0]  brk_valid;
  logic [31:0] cyc;
  logic [23:0] disp;
  logic [15:0] brk_addr2;
  logic [0:0]  brk_valid2;
  logic [2:0]  cyc2;
  logic [15:0] disp2;
`ifdef CR16_RUN_CTRL_WATCHDOG_EN
  logic        wd_trip, wd_trip2;
`endif

  int n_vec = 0;
  int n_err = 0;

  cr16_run_ctrl_if bus ();
  cr16_run_ctrl_if bus2 ();

  cr16_run_ctrl dut (
    .I_CLK         (clk),
    .I_NRESET      (nrst),
    .bus           (bus),
    .I_BREAK_ADDR  (brk_addr),
    .I_BREAK_VALID (brk_valid),
    .O_CYCLE_COUNT (cyc),
    .O_DISPLAY_BITS(disp)
`ifdef CR16_RUN_CTRL_WATCHDOG_EN
    , .O_WATCHDOG_TRIP(wd_trip)
`endif
  );

  cr16_run_ctrl #(
    .P_WARMUP_CYCLES  (16'd1),
    .P_AUTO_RUN       (1'b0),
    .P_ENABLE_MAX_PC  (1'b0),
    .P_NUM_BREAKPOINTS(1),
    .P_NUM_DIGITS     (4),
    .P_CYCLE_WIDTH    (3)
  ) dut2 (
    .I_CLK         (clk),
    .I_NRESET      (nrst2),
    .bus           (bus2),
    .I_BREAK_ADDR  (brk_addr2),
    .I_BREAK_VALID (brk_valid2),
    .O_CYCLE_COUNT (cyc2),
    .O_DISPLAY_BITS(disp2)
`ifdef CR16_RUN_CTRL_WATCHDOG_EN
    , .O_WATCHDOG_TRIP(wd_trip2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, halt, step;
    logic [15:0] pc;
    logic [1:0]  bv;
    logic        en;
    logic [1:0]  st, cause;
    logic [2:0]  idx;
    logic [31:0] cnt;
    logic [23:0] disp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic h, input logic s, input logic [15:0] pc,
                              input logic [1:0] bv, input logic en, input logic [1:0] st,
                              input logic [1:0] c, input logic [2:0] i, input logic [31:0] cnt);
    vec_t v;
    v.run = r; v.halt = h; v.step = s; v.pc = pc; v.bv = bv;
    v.en = en; v.st = st; v.cause = c; v.idx = i; v.cnt = cnt;
    v.disp = (st == 2'd2) ? 24'h00BEEF : {pc[7:0], 16'h1234};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic en, input logic [1:0] st, input logic [1:0] c,
                          input logic [2:0] i, input logic [31:0] cnt, input logic [23:0] d);
    n_vec++;
    chk({tag, " enable"}, 32'(bus.O_CPU_ENABLE), 32'(en));
    chk({tag, " state"},  32'(bus.O_STATE), 32'(st));
    chk({tag, " cause"},  32'(bus.O_HALT_CAUSE), 32'(c));
    chk({tag, " index"},  32'(bus.O_BREAK_INDEX), 32'(i));
    chk({tag, " cycles"}, cyc, cnt);
    chk({tag, " display"}, 32'(disp), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.I_RUN = 0; bus.I_HALT = 0; bus.I_STEP = 0; bus.I_PC = 16'd0;
    bus.I_RESULT_BUS = 16'h1234; bus.I_INSPECT_DATA = 16'hBEEF;
    brk_addr = {16'h0005, 16'h0007}; brk_valid = 2'b00;
    bus2.I_RUN = 0; bus2.I_HALT = 0; bus2.I_STEP = 0; bus2.I_PC = 16'd100;
    bus2.I_RESULT_BUS = 16'h1234; bus2.I_INSPECT_DATA = 16'hBEEF;
    brk_addr2 = 16'h0064; brk_valid2 = 1'b0;

    // warm-up, run to breakpoint 1, resume over it, halt at breakpoint 0
    add(0,0,0, 0,0, 0,0,0,0, 0);
    add(0,0,0, 0,0, 0,0,0,0, 0);
    add(0,0,0, 0,0, 1,1,0,0, 0);
    add(0,0,0, 1,0, 1,1,0,0, 1);
    add(0,0,0, 2,0, 1,1,0,0, 2);
    add(0,0,0, 3,2, 1,1,0,0, 3);
    add(0,0,0, 4,2, 1,1,0,0, 4);
    add(0,0,0, 5,2, 0,1,0,0, 5);
    add(0,0,0, 5,2, 0,2,3,1, 5);
    add(1,0,0, 5,2, 0,2,3,1, 5);
    add(1,0,0, 5,2, 1,1,0,1, 5);
    add(0,0,0, 6,2, 1,1,0,1, 6);
    add(0,0,0, 7,3, 0,1,0,1, 7);
    add(0,0,0, 7,3, 0,2,3,0, 7);
    // step held for five cycles
    add(0,0,1, 7,3, 0,2,3,0, 7);
    add(0,0,1, 7,3, 1,3,3,0, 7);
    for (int k = 0; k < 3; k++) add(0,0,1, 7,3, 0,2,3,0, 8);
    add(0,0,0, 8,0, 0,2,3,0, 8);
    // run again, then halt and run rising together
    add(1,0,0, 8,0, 0,2,3,0, 8);
    add(1,0,0, 8,0, 1,1,0,0, 8);
    add(0,0,0, 9,0, 1,1,0,0, 9);
    add(1,1,0, 10,0, 0,1,0,0, 10);
    add(1,1,0, 10,0, 0,2,1,0, 10);
    add(0,0,0, 10,0, 0,2,1,0, 10);
    add(1,0,0, 10,0, 0,2,1,0, 10);
    add(1,0,0, 10,0, 1,1,0,0, 10);
    // PC walks up to the max-PC limit
    for (int p = 11; p <= 20; p++) add(0,0,0, 16'(p),0, 1,1,0,0, 32'(p));
    add(0,0,0, 21,0, 0,1,0,0, 21);
    add(0,0,0, 21,0, 0,2,2,0, 21);
    add(1,0,0, 21,0, 0,2,2,0, 21);
    add(1,0,0, 21,0, 0,2,2,0, 21);
    add(0,0,1, 21,0, 0,2,2,0, 21);
    add(0,0,1, 21,0, 0,2,2,0, 21);
    add(0,0,0, 3,0, 0,2,2,0, 21);
    add(1,0,0, 3,0, 0,2,2,0, 21);
    for (int j = 0; j <= 16; j++) add(0,0,0, 3,0, 1,1,0,0, 32'(21 + j));

    repeat (3) @(posedge clk);
    #1;
    chk_main("reset", 1'b0, 2'd0, 2'd0, 3'd0, 32'd0, 24'h001234);
    nrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus.I_RUN = tbl[i].run; bus.I_HALT = tbl[i].halt; bus.I_STEP = tbl[i].step;
      bus.I_PC = tbl[i].pc; brk_valid = tbl[i].bv;
      #1;
      chk_main($sformatf("row%0d", i), tbl[i].en, tbl[i].st, tbl[i].cause,
               tbl[i].idx, tbl[i].cnt, tbl[i].disp);
    end

    // asynchronous reset in RUN with 37 executed cycles
    nrst = 1'b0;
    #1;
    chk_main("midreset", 1'b0, 2'd0, 2'd0, 3'd0, 32'd0, 24'h031234);
    @(posedge clk); #1; nrst = 1'b1; #1;
    chk_main("rewarm0", 1'b0, 2'd0, 2'd0, 3'd0, 32'd0, 24'h031234);
    @(posedge clk); #2;
    chk_main("rewarm1", 1'b0, 2'd0, 2'd0, 3'd0, 32'd0, 24'h031234);
    @(posedge clk); #2;
    chk_main("rerun0", 1'b1, 2'd1, 2'd0, 3'd0, 32'd0, 24'h031234);
    @(posedge clk); #2;
    chk_main("rerun1", 1'b1, 2'd1, 2'd0, 3'd0, 32'd1, 24'h031234);

    // second instance: 1-cycle warm-up into HALTED, 4 digits, 3-bit saturating counter
    @(posedge clk); #1; nrst2 = 1'b1; #1;
    n_vec++;
    chk("d2 warm state", 32'(bus2.O_STATE), 32'd0);
    chk("d2 warm enable", 32'(bus2.O_CPU_ENABLE), 32'd0);
    @(posedge clk); #2;
    n_vec++;
    chk("d2 halted state", 32'(bus2.O_STATE), 32'd2);
    chk("d2 halted display", 32'(disp2), 32'h0000BEEF);
    bus2.I_RUN = 1'b1; #1;
    chk("d2 req state", 32'(bus2.O_STATE), 32'd2);
    @(posedge clk); #2;
    n_vec++;
    chk("d2 run state", 32'(bus2.O_STATE), 32'd1);
    chk("d2 run enable", 32'(bus2.O_CPU_ENABLE), 32'd1);
    chk("d2 run display", 32'(disp2), 32'h00001234);
    chk("d2 run cycles", 32'(cyc2), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #2;
      n_vec++;
      chk($sformatf("d2 sat%0d cycles", k), 32'(cyc2), (k < 7) ? 32'(k) : 32'd7);
      chk($sformatf("d2 sat%0d enable", k), 32'(bus2.O_CPU_ENABLE), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
